// File: rtl/ula_pkg.sv
// ula_pkg: opcodes, FSM states and default width shared by the multi-cycle ALU
package ula_pkg;
    localparam int LARGURA_PADRAO = 32;
    typedef enum logic [2:0] {
        OP_ADD       = 3'b000,
        OP_SUB       = 3'b001,
        OP_AND       = 3'b010,
        OP_OR        = 3'b011,
        OP_SLT       = 3'b100,
        OP_MULU      = 3'b101,
        OP_DIVU      = 3'b110,
        OP_RESERVADO = 3'b111
    } opcode_t;
    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        CONCLUI = 2'd2
    } estado_t;
endpackage

// File: rtl/ula_multiciclo_if.sv
// ula_multiciclo_if: start/busy/done handshake and operand/result bus of the ALU
interface ula_multiciclo_if #(parameter int DATA_WIDTH = ula_pkg::LARGURA_PADRAO);
    logic                  inicio;
    logic [2:0]            operacao;
    logic [DATA_WIDTH-1:0] operandoA;
    logic [DATA_WIDTH-1:0] operandoB;
    logic [DATA_WIDTH-1:0] resultado;
    logic [DATA_WIDTH-1:0] resultado_alto;
    logic                  zero;
    logic                  div_por_zero;
    logic                  ocupado;
    logic                  pronto;
    modport master (
        output inicio, operacao, operandoA, operandoB,
        input  resultado, resultado_alto, zero, div_por_zero, ocupado, pronto
    );
    modport slave (
        input  inicio, operacao, operandoA, operandoB,
        output resultado, resultado_alto, zero, div_por_zero, ocupado, pronto
    );
endinterface

// File: rtl/mul_div_iterativo.sv
// mul_div_iterativo: one-bit-per-step shift/add multiplier and restoring divider
module mul_div_iterativo #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  carrega,
    input  logic                  passo,
    input  logic                  eh_div,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi
);
    logic [DATA_WIDTH-1:0] acc, mq, md, acc_n, mq_n, dif;
    logic [DATA_WIDTH:0]   soma, desl;
    logic                  modo, ge;
    // lo/hi are the post-step values so the last step's result is usable at the same edge
    always_comb begin
        soma  = {1'b0, acc} + (mq[0] ? {1'b0, md} : '0);
        desl  = {acc, mq[DATA_WIDTH-1]};
        ge    = desl >= {1'b0, md};
        dif   = desl[DATA_WIDTH-1:0] - md;
        acc_n = modo ? (ge ? dif : desl[DATA_WIDTH-1:0]) : soma[DATA_WIDTH:1];
        mq_n  = modo ? {mq[DATA_WIDTH-2:0], ge} : {soma[0], mq[DATA_WIDTH-1:1]};
        lo    = mq_n;
        hi    = acc_n;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            mq   <= '0;
            md   <= '0;
            modo <= 1'b0;
        end else if (carrega) begin
            acc  <= '0;
            mq   <= a;
            md   <= b;
            modo <= eh_div;
        end else if (passo) begin
            acc <= acc_n;
            mq  <= mq_n;
        end
    end
endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: ALU with single-cycle logic/arith ops and iterative MULU/DIVU
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int DATA_WIDTH = LARGURA_PADRAO
) (
    input logic              clk,
    input logic              rst,
    ula_multiciclo_if.slave  bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    estado_t               estado, prox;
    opcode_t               op_q;
    logic                  bz_q, iterativa, carrega, zero_q, dz_q;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] simples, res_q, alto_q, it_lo, it_hi;
    always_comb begin
        simples   = bus.operacao == OP_ADD ? bus.operandoA + bus.operandoB :
                    bus.operacao == OP_SUB ? bus.operandoA - bus.operandoB :
                    bus.operacao == OP_AND ? bus.operandoA & bus.operandoB :
                    bus.operacao == OP_OR  ? bus.operandoA | bus.operandoB :
                    bus.operacao == OP_SLT ? {{(DATA_WIDTH-1){1'b0}}, $signed(bus.operandoA) < $signed(bus.operandoB)} :
                    '0;
        iterativa = bus.operacao == OP_MULU || bus.operacao == OP_DIVU;
        carrega   = estado == OCIOSO && bus.inicio && iterativa;
        prox      = estado;
        case (estado)
            OCIOSO:  if (bus.inicio) prox = iterativa ? CALCULA : CONCLUI;
            CALCULA: if (cnt == '0) prox = CONCLUI;
            CONCLUI: prox = OCIOSO;
            default: prox = OCIOSO;
        endcase
    end
    mul_div_iterativo #(.DATA_WIDTH(DATA_WIDTH)) u_md (
        .clk    (clk),
        .rst    (rst),
        .carrega(carrega),
        .passo  (estado == CALCULA),
        .eh_div (bus.operacao == OP_DIVU),
        .a      (bus.operandoA),
        .b      (bus.operandoB),
        .lo     (it_lo),
        .hi     (it_hi)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= OCIOSO;
            op_q   <= OP_ADD;
            bz_q   <= 1'b0;
            cnt    <= '0;
            res_q  <= '0;
            alto_q <= '0;
            zero_q <= 1'b1;
            dz_q   <= 1'b0;
        end else begin
            estado <= prox;
            if (estado == OCIOSO && bus.inicio) begin
                op_q <= opcode_t'(bus.operacao);
                bz_q <= bus.operandoB == '0;
                if (iterativa) begin
                    cnt <= CW'(DATA_WIDTH - 1);
                end else begin
                    res_q  <= simples;
                    alto_q <= '0;
                    zero_q <= simples == '0;
                    dz_q   <= 1'b0;
                end
            end
            if (estado == CALCULA) begin
                if (cnt == '0) begin
                    res_q  <= it_lo;
                    alto_q <= it_hi;
                    zero_q <= it_lo == '0;
                    dz_q   <= op_q == OP_DIVU && bz_q;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
    assign bus.resultado      = res_q;
    assign bus.resultado_alto = alto_q;
    assign bus.zero           = zero_q;
    assign bus.div_por_zero   = dz_q;
    assign bus.ocupado        = estado != OCIOSO;
    assign bus.pronto         = estado == CONCLUI;
endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: directed vectors against an arithmetic reference model of the ALU
module tb_ula_multiciclo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   erros = 0;
    ula_multiciclo_if #(.DATA_WIDTH(32)) bus();
    ula_multiciclo #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        vecs++;
        if (atual !== esperado) begin
            erros++;
            $display("FAIL %s: got %h expected %h at %0t", nome, atual, esperado, $time);
        end
    endtask
    // reference: results from plain arithmetic, timing from the documented latencies
    logic        m_busy = 0, m_pronto = 0, m_dz = 0, p_dz;
    logic [31:0] m_lo = 0, m_hi = 0;
    logic [63:0] p_res;
    int          m_rem = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_pronto = 0; m_rem = 0; m_lo = 0; m_hi = 0; m_dz = 0;
        end else if (m_pronto) begin
            m_pronto = 0;
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 0; m_pronto = 1; {m_hi, m_lo} = p_res; m_dz = p_dz;
            end
        end else if (bus.inicio) begin
            p_dz = 0;
            case (bus.operacao)
                3'b000: p_res = {32'h0, bus.operandoA + bus.operandoB};
                3'b001: p_res = {32'h0, bus.operandoA - bus.operandoB};
                3'b010: p_res = {32'h0, bus.operandoA & bus.operandoB};
                3'b011: p_res = {32'h0, bus.operandoA | bus.operandoB};
                3'b100: p_res = ($signed(bus.operandoA) < $signed(bus.operandoB)) ? 64'd1 : 64'd0;
                3'b101: p_res = {32'h0, bus.operandoA} * {32'h0, bus.operandoB};
                3'b110: begin
                    p_dz  = bus.operandoB == 0;
                    p_res = p_dz ? {bus.operandoA, 32'hFFFF_FFFF}
                                 : {bus.operandoA % bus.operandoB, bus.operandoA / bus.operandoB};
                end
                default: p_res = 64'h0;
            endcase
            if (bus.operacao == 3'b101 || bus.operacao == 3'b110) begin
                m_busy = 1; m_rem = 32;
            end else begin
                m_pronto = 1; {m_hi, m_lo} = p_res; m_dz = p_dz;
            end
        end
    end
    always @(negedge clk) begin
        chk("pronto", 64'(bus.pronto), 64'(m_pronto));
        chk("ocupado", 64'(bus.ocupado), 64'(m_busy || m_pronto));
        chk("resultado", 64'(bus.resultado), 64'(m_lo));
        chk("resultado_alto", 64'(bus.resultado_alto), 64'(m_hi));
        chk("zero", 64'(bus.zero), 64'(m_lo == 0));
        chk("div_por_zero", 64'(bus.div_por_zero), 64'(m_dz));
    end
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_lo, input logic [31:0] e_hi, input logic e_dz,
                          input int e_lat, input bit mexe);
        int  n = 0;
        bit  got = 0;
        @(negedge clk);
        bus.inicio = 1; bus.operacao = op; bus.operandoA = a; bus.operandoB = b;
        @(posedge clk);
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            bus.inicio = mexe && (n % 3 != 2);
            if (mexe) begin
                bus.operandoA = $urandom; bus.operandoB = $urandom; bus.operacao = 3'($urandom_range(0, 7));
            end
            if (bus.pronto) got = 1;
        end
        bus.inicio = 0;
        chk("latencia", 64'(got ? n : 999), 64'(e_lat));
        chk("lit_resultado", 64'(bus.resultado), 64'(e_lo));
        chk("lit_alto", 64'(bus.resultado_alto), 64'(e_hi));
        chk("lit_zero", 64'(bus.zero), 64'(e_lo == 0));
        chk("lit_dz", 64'(bus.div_por_zero), 64'(e_dz));
    endtask
    task automatic chk_reset_lits();
        chk("rst_resultado", 64'(bus.resultado), 64'h0);
        chk("rst_alto", 64'(bus.resultado_alto), 64'h0);
        chk("rst_zero", 64'(bus.zero), 64'h1);
        chk("rst_dz", 64'(bus.div_por_zero), 64'h0);
        chk("rst_ocupado", 64'(bus.ocupado), 64'h0);
        chk("rst_pronto", 64'(bus.pronto), 64'h0);
    endtask
    initial begin
        bus.inicio = 0; bus.operacao = 0; bus.operandoA = 0; bus.operandoB = 0;
        repeat (3) @(negedge clk);
        chk_reset_lits();
        rst = 0;
        run_op(3'b000, 32'd7, 32'd5, 32'd12, 0, 0, 1, 0);
        run_op(3'b001, 32'd5, 32'd5, 32'd0, 0, 0, 1, 1);
        run_op(3'b100, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 1, 0);
        run_op(3'b100, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 0, 1, 0);
        run_op(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 1, 0);
        run_op(3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 0, 1, 0);
        run_op(3'b111, 32'd5, 32'd6, 32'd0, 0, 0, 1, 0);
        run_op(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0, 33, 1);
        run_op(3'b101, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1, 0, 33, 0);
        run_op(3'b110, 32'd100, 32'd7, 32'd14, 32'd2, 0, 33, 0);
        run_op(3'b110, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1, 33, 1);
        run_op(3'b000, 32'd1, 32'd1, 32'd2, 0, 0, 1, 0);
        run_op(3'b110, 32'd5, 32'd9, 32'd0, 32'd5, 0, 33, 0);
        run_op(3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 0, 1, 0);
        @(negedge clk);
        bus.inicio = 1; bus.operacao = 3'b101; bus.operandoA = 32'd3; bus.operandoB = 32'd3;
        @(negedge clk);
        bus.inicio = 0;
        repeat (9) @(negedge clk);
        #2 rst = 1;
        #1 chk_reset_lits();
        @(negedge clk);
        #2 rst = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("sem_pronto", 64'(bus.pronto), 64'h0);
        end
        run_op(3'b000, 32'd3, 32'd4, 32'd7, 0, 0, 1, 0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, erros);
        $finish;
    end
endmodule
